adc_fill_acq_ctrl: RTL and testbench
====================================

# adc_fill_acq_ctrl

Per-channel acquisition controller directly downstream of the fill-size mux (`adc_fill_size_mux`). On a fill trigger it supplies the fill type to the mux and pulses the mux enable. It then latches the resulting burst count and streams exactly that many sample bursts of ADC data into the channel buffer with incrementing addresses. Finally it holds a done/ack handshake toward readout.

## Interface
Parameters:
- `DATA_W`, 12: ADC sample width.
- `ADDR_W`, 28: buffer sample-address width; must hold 24-bit bursts × burst length.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high.
- `trigger`, in, 1: fill start pulse; sampled only in IDLE.
- `fill_type`, in, 2: fill type; 00 none, 01 muon, 10 laser, 11 pedestal. Valid with `trigger`.
- `mux_fill_type`, out, 2: registered fill type driven to the mux.
- `mux_enable`, out, 1: enable to the mux; high for exactly one cycle per fill.
- `num_fill_bursts`, in, 24: registered burst count returned by the mux.
- `adc_valid`, in, 1: one sample per cycle while high.
- `adc_data`, in, DATA_W: sample.
- `wr_en`, out, 1: buffer write strobe.
- `wr_addr`, out, ADDR_W: buffer sample address.
- `wr_data`, out, DATA_W: buffer write data.
- `busy`, out, 1: state ≠ IDLE.
- `fill_done`, out, 1: level; fill complete, awaiting ack.
- `done_ack`, in, 1: readout acknowledge.
- `fill_len`, out, 24: latched burst count of the current or last fill.
- `fill_num`, out, 24: completed-fill counter.
- `trig_overrun`, out, 16: triggers ignored while busy.

## Operation
- Reset: state IDLE. Every output is 0, including `fill_num`, `fill_len` and `trig_overrun`.
- IDLE:
  - On `trigger`, register `mux_fill_type <= fill_type` and go to SIZE.
  - Clear the sample and burst counters.
  - Reset `wr_addr` to 0 for the new fill.
- SIZE (1 cycle): `mux_enable = 1`, then go to LOAD.
- LOAD (1 cycle): `fill_len <= num_fill_bursts`. If the value is 0 (e.g. type 00), go to DONE; otherwise go to ACQ.
- ACQ, each cycle with `adc_valid`:
  - Write the sample to `wr_data` and `wr_addr`; then `wr_addr++`.
  - The sample counter counts 0..BURST_LEN−1. On wrap the burst counter increments.
  - When the last sample of burst `fill_len−1` is written, go to DONE. No further writes occur even if `adc_valid` stays high.
  - A cycle with `adc_valid` low pauses counting with no write.
- DONE: `fill_done = 1`. When `done_ack` is seen, in the same cycle go to IDLE, drop `fill_done` next cycle, and increment `fill_num`. `fill_num` wraps at 2^24 to 0.
- `trigger` outside IDLE is ignored and increments `trig_overrun`, saturating at 0xFFFF.
- `done_ack` outside DONE is ignored.
- Simultaneous `done_ack` and `trigger` in DONE: the trigger counts as an overrun and is not started.
- `reset` mid-fill aborts immediately to IDLE. No partial `fill_done` is produced and all counters clear.
- Address arithmetic is unsigned, with no overflow check. `fill_len × BURST_LEN` fits ADDR_W at the default width.

## Timing
- Trigger to first possible write: trigger sampled at edge T0; SIZE at T1; LOAD at T2; ACQ from T3. An `adc_valid` sampled at T3 appears on `wr_en` after edge T3.
- `wr_en`, `wr_addr` and `wr_data` are registered: one cycle after the `adc_valid`/`adc_data` they carry.
- `fill_done` rises the cycle after the final write is issued.
- Ack-to-ready: `done_ack` sampled at edge A; IDLE and `busy` low after A. The next trigger is accepted at edge A+1.
- `mux_enable` has no combinational paths from inputs. All outputs are registered.

## Configuration
- `ADC_BURST10_EN` defined: BURST_LEN = 10 samples per burst.
- Not defined: BURST_LEN = 8.
- Only the sample-counter wrap value and the package constant change. The interface is identical.

## Structure
- Package `adc_acq_pkg` holds:
  - the state enum (IDLE, SIZE, LOAD, ACQ, DONE);
  - fill-type constants FILL_NONE/MUON/LASER/PED;
  - BURST_LEN, selected by `ADC_BURST10_EN`;
  - the 24-bit burst-count width constant.
- One sub-module, `adc_burst_counter`:
  - sample and burst counters with increment and clear;
  - a `last` flag asserted when burst = `fill_len−1` and sample = BURST_LEN−1.
- The FSM and output registers stay in the top module.

## Test plan
- Muon fill, with the mux stub returning 3, `adc_valid` held high, BURST_LEN 8: exactly 24 writes, addresses 0..23, `fill_done` after the last write; ack gives `fill_num` = 1.
- Fill type 00 (mux returns 0): SIZE → LOAD → DONE with zero writes, `fill_len` = 0; ack still increments `fill_num`.
- Laser fill of 2 bursts with `adc_valid` toggling every other cycle: 16 writes; `wr_data` equals `adc_data` delayed one cycle; no write on idle cycles.
- Three triggers during ACQ plus one in DONE coincident with `done_ack`: `trig_overrun` = 4, and the fill completes unaffected.
- `reset` asserted mid-ACQ after 5 writes: next cycle all outputs are 0, and a new 1-burst fill writes from address 0.
- `ADC_BURST10_EN` build, pedestal fill of 2 bursts: 20 writes, `last` at address 19.

Source files
------------

// File: rtl/adc_fill_acq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adc_acq_pkg
// Description : Shared types and constants for the ADC fill acquisition
//               controller. Build macro ADC_BURST10_EN selects 10-sample
//               bursts; otherwise bursts are 8 samples long.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_acq_pkg;

    localparam int BURST_CNT_W = 24;

`ifdef ADC_BURST10_EN
    localparam int BURST_LEN = 10;
`else
    localparam int BURST_LEN = 8;
`endif

    localparam int SAMPLE_W = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SIZE = 3'd1,
        ST_LOAD = 3'd2,
        ST_ACQ  = 3'd3,
        ST_DONE = 3'd4
    } acq_state_e;

    localparam logic [1:0] FILL_NONE  = 2'b00;
    localparam logic [1:0] FILL_MUON  = 2'b01;
    localparam logic [1:0] FILL_LASER = 2'b10;
    localparam logic [1:0] FILL_PED   = 2'b11;

endpackage : adc_acq_pkg
`default_nettype wire

// File: rtl/adc_fill_acq_ctrl_burst_counter.sv
`default_nettype none
// ============================================================================
// Module      : adc_burst_counter
// Description : Sample-within-burst and burst counters for one fill, with a
//               flag marking the final sample of the final burst.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_burst_counter
    import adc_acq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   inc,
    input  logic [BURST_CNT_W-1:0] fill_len,
    output logic                   last
);

    localparam logic [SAMPLE_W-1:0] c_sample_max = SAMPLE_W'(BURST_LEN - 1);

    logic [SAMPLE_W-1:0]    r_sample;
    logic [BURST_CNT_W-1:0] r_burst;
    logic                   w_sample_wrap;

    assign w_sample_wrap = (r_sample == c_sample_max);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_sample <= '0;
            r_burst  <= '0;
        end else if (inc) begin
            if (w_sample_wrap) begin
                r_sample <= '0;
                r_burst  <= r_burst + BURST_CNT_W'(1);
            end else begin
                r_sample <= r_sample + SAMPLE_W'(1);
            end
        end
    end

    // Only meaningful while fill_len is non-zero; zero-length fills never count.
    assign last = w_sample_wrap && (r_burst == (fill_len - BURST_CNT_W'(1)));

endmodule : adc_burst_counter
`default_nettype wire

// File: rtl/adc_fill_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_fill_acq_ctrl
// Description : Per-channel fill acquisition controller: sizes the fill via the
//               fill-size mux, streams bursts into the channel buffer, then
//               holds a done/ack handshake. ADC_BURST10_EN selects 10-sample
//               bursts (default 8).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_fill_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [1:0]             fill_type,
    output logic [1:0]             mux_fill_type,
    output logic                   mux_enable,
    input  logic [BURST_CNT_W-1:0] num_fill_bursts,
    input  logic                   adc_valid,
    input  logic [DATA_W-1:0]      adc_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
    output logic                   fill_done,
    input  logic                   done_ack,
    output logic [BURST_CNT_W-1:0] fill_len,
    output logic [BURST_CNT_W-1:0] fill_num,
    output logic [15:0]            trig_overrun
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_SIZE = ST_SIZE;
    localparam logic [2:0] S_LOAD = ST_LOAD;
    localparam logic [2:0] S_ACQ  = ST_ACQ;
    localparam logic [2:0] S_DONE = ST_DONE;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   w_write;
    logic                   w_last;
    logic                   w_start;

    logic [1:0]             r_mux_fill_type;
    logic                   r_mux_enable;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [ADDR_W-1:0]      r_next_addr;
    logic [DATA_W-1:0]      r_wr_data;
    logic                   r_busy;
    logic                   r_fill_done;
    logic [BURST_CNT_W-1:0] r_fill_len;
    logic [BURST_CNT_W-1:0] r_fill_num;
    logic [15:0]            r_trig_overrun;

    assign w_start = (r_state == S_IDLE) && trigger;
    assign w_write = (r_state == S_ACQ) && adc_valid;

    adc_burst_counter u_burst_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (r_state == S_IDLE),
        .inc      (w_write),
        .fill_len (r_fill_len),
        .last     (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (trigger) w_state_nxt = S_SIZE;
            S_SIZE: w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = (num_fill_bursts == '0) ? S_DONE : S_ACQ;
            S_ACQ:  if (w_write && w_last) w_state_nxt = S_DONE;
            S_DONE: if (done_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_mux_fill_type <= '0;
            r_mux_enable    <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_next_addr     <= '0;
            r_wr_data       <= '0;
            r_busy          <= 1'b0;
            r_fill_done     <= 1'b0;
            r_fill_len      <= '0;
            r_fill_num      <= '0;
            r_trig_overrun  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_fill_done  <= (w_state_nxt == S_DONE);
            r_mux_enable <= w_start;
            r_wr_en      <= w_write;

            if (w_start) begin
                r_mux_fill_type <= fill_type;
            end

            if (r_state == S_LOAD) begin
                r_fill_len <= num_fill_bursts;
            end

            // Address restarts at zero every time the controller sits idle.
            if (w_write) begin
                r_wr_addr   <= r_next_addr;
                r_wr_data   <= adc_data;
                r_next_addr <= r_next_addr + ADDR_W'(1);
            end else if (r_state == S_IDLE) begin
                r_wr_addr   <= '0;
                r_next_addr <= '0;
            end

            if ((r_state == S_DONE) && done_ack) begin
                r_fill_num <= r_fill_num + BURST_CNT_W'(1);
            end

            if (trigger && (r_state != S_IDLE) && (r_trig_overrun != 16'hFFFF)) begin
                r_trig_overrun <= r_trig_overrun + 16'd1;
            end
        end
    end

    assign mux_fill_type = r_mux_fill_type;
    assign mux_enable    = r_mux_enable;
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign busy          = r_busy;
    assign fill_done     = r_fill_done;
    assign fill_len      = r_fill_len;
    assign fill_num      = r_fill_num;
    assign trig_overrun  = r_trig_overrun;

endmodule : adc_fill_acq_ctrl
`default_nettype wire

// File: tb/tb_adc_fill_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_fill_acq_ctrl
// Description : Self-checking bench for adc_fill_acq_ctrl with a fill-size mux
//               stub and a count-based reference model of each fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_fill_acq_ctrl;
    import adc_acq_pkg::*;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 28;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   trigger;
    logic [1:0]             fill_type;
    logic [1:0]             mux_fill_type;
    logic                   mux_enable;
    logic [BURST_CNT_W-1:0] num_fill_bursts = '0;
    logic                   adc_valid;
    logic [DATA_W-1:0]      adc_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;
    logic                   fill_done;
    logic                   done_ack;
    logic [BURST_CNT_W-1:0] fill_len;
    logic [BURST_CNT_W-1:0] fill_num;
    logic [15:0]            trig_overrun;

    logic [BURST_CNT_W-1:0] stub_len [4];
    int n_checks = 0;
    int n_err    = 0;
    int exp_fill_num = 0;
    int exp_overrun  = 0;

    always #5 clk = ~clk;

    // Fill-size mux stub: registers the burst count for the type it is enabled with.
    always @(posedge clk) begin
        if (mux_enable) num_fill_bursts <= stub_len[mux_fill_type];
    end

    adc_fill_acq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .trigger         (trigger),
        .fill_type       (fill_type),
        .mux_fill_type   (mux_fill_type),
        .mux_enable      (mux_enable),
        .num_fill_bursts (num_fill_bursts),
        .adc_valid       (adc_valid),
        .adc_data        (adc_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .fill_done       (fill_done),
        .done_ack        (done_ack),
        .fill_len        (fill_len),
        .fill_num        (fill_num),
        .trig_overrun    (trig_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mux_fill_type"}, 32'(mux_fill_type), 0);
        chk({tag, "_mux_enable"},    32'(mux_enable),    0);
        chk({tag, "_wr_en"},         32'(wr_en),         0);
        chk({tag, "_wr_addr"},       32'(wr_addr),       0);
        chk({tag, "_wr_data"},       32'(wr_data),       0);
        chk({tag, "_busy"},          32'(busy),          0);
        chk({tag, "_fill_done"},     32'(fill_done),     0);
        chk({tag, "_fill_len"},      32'(fill_len),      0);
        chk({tag, "_fill_num"},      32'(fill_num),      0);
        chk({tag, "_trig_overrun"},  32'(trig_overrun),  0);
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // mode: 0 = adc_valid always high, 1 = toggling, 2 = random ~60% duty
    task automatic do_fill(input logic [1:0] ftype, input int mode, input int n_trig,
                           input bit trig_on_ack);
        int exp_len, total, written, cyc;
        logic v;
        logic [DATA_W-1:0] d;
        exp_len = int'(stub_len[ftype]);
        total   = exp_len * BURST_LEN;

        trigger = 1'b1; fill_type = ftype; adc_valid = 1'b1; adc_data = DATA_W'($urandom);
        step();
        trigger = 1'b0; fill_type = 2'($urandom);
        chk("size_mux_enable", 32'(mux_enable), 1);
        chk("size_mux_type", 32'(mux_fill_type), 32'(ftype));
        chk("size_busy", 32'(busy), 1);
        chk("size_wr_en", 32'(wr_en), 0);
        step();
        chk("load_mux_enable", 32'(mux_enable), 0);
        chk("load_wr_en", 32'(wr_en), 0);
        step();
        chk("fill_len", 32'(fill_len), exp_len);
        chk("post_load_wr_en", 32'(wr_en), 0);
        chk("post_load_fill_done", 32'(fill_done), 32'(total == 0));

        written = 0;
        cyc = 0;
        while (written < total) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = ($urandom_range(99) < 60);
            endcase
            d = DATA_W'($urandom);
            adc_valid = v;
            adc_data  = d;
            trigger   = (cyc < n_trig);
            done_ack  = ($urandom_range(3) == 0);
            step();
            if (cyc < n_trig) exp_overrun = sat_inc(exp_overrun);
            chk("acq_wr_en", 32'(wr_en), 32'(v));
            if (v) begin
                chk("acq_wr_addr", 32'(wr_addr), written);
                chk("acq_wr_data", 32'(wr_data), 32'(d));
                written++;
            end
            chk("acq_fill_done", 32'(fill_done), 32'(written == total));
            chk("acq_fill_num", 32'(fill_num), exp_fill_num);
            cyc++;
            if (cyc > 4000) begin
                chk("acq_timeout", 0, 1);
                break;
            end
        end

        trigger = 1'b0; done_ack = 1'b0; adc_valid = 1'b1;
        repeat (3) begin
            adc_data = DATA_W'($urandom);
            step();
            chk("done_wr_en", 32'(wr_en), 0);
            chk("done_fill_done", 32'(fill_done), 1);
            chk("done_busy", 32'(busy), 1);
            chk("done_trig_overrun", 32'(trig_overrun), exp_overrun);
        end

        done_ack = 1'b1; trigger = trig_on_ack; adc_valid = 1'b0;
        step();
        done_ack = 1'b0; trigger = 1'b0;
        exp_fill_num = (exp_fill_num + 1) % (1 << 24);
        if (trig_on_ack) exp_overrun = sat_inc(exp_overrun);
        chk("ack_busy", 32'(busy), 0);
        chk("ack_fill_done", 32'(fill_done), 0);
        chk("ack_fill_num", 32'(fill_num), exp_fill_num);
        chk("ack_trig_overrun", 32'(trig_overrun), exp_overrun);
        chk("ack_fill_len", 32'(fill_len), exp_len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] ft;
        reset = 1'b1; trigger = 1'b0; fill_type = '0; adc_valid = 1'b0;
        adc_data = '0; done_ack = 1'b0;
        stub_len[0] = 24'd0; stub_len[1] = 24'd3; stub_len[2] = 24'd2; stub_len[3] = 24'd2;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        do_fill(FILL_MUON, 0, 0, 1'b0);
        do_fill(FILL_NONE, 0, 0, 1'b0);
        do_fill(FILL_LASER, 1, 0, 1'b0);
        do_fill(FILL_PED, 2, 3, 1'b1);

        for (int k = 0; k < 5; k++) begin
            ft = 2'($urandom);
            stub_len[ft] = BURST_CNT_W'($urandom_range(0, 4));
            do_fill(ft, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        // Abort a fill after five writes.
        stub_len[1] = 24'd3;
        trigger = 1'b1; fill_type = FILL_MUON;
        step();
        trigger = 1'b0;
        repeat (2) step();
        adc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adc_data = DATA_W'($urandom);
            step();
            chk("abort_wr_addr", 32'(wr_addr), i);
        end
        reset = 1'b1; adc_valid = 1'b0;
        step();
        reset = 1'b0;
        check_all_zero("midreset");
        exp_fill_num = 0;
        exp_overrun  = 0;
        step();
        chk("midreset_idle_busy", 32'(busy), 0);
        chk("midreset_idle_done", 32'(fill_done), 0);

        stub_len[2] = 24'd1;
        do_fill(FILL_LASER, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_adc_fill_acq_ctrl
`default_nettype wire
